// File: rtl/stopwatch_lap_timer_if.sv
// stopwatch_lap_timer_if: command and display bundle between the button debouncers, the stopwatch and the display mux
// master drives: start, pause, clear, dir, load, load_hr/min/sec, lap, lap_pop
// master reads:  one_sec, BCD digits, lap_data, lap_count, lap_ovf, running, expired, mode_at
interface stopwatch_lap_timer_if #(
  parameter int LAP_DEPTH = 4
);
  localparam int CW = $clog2(LAP_DEPTH) + 1;
  logic start;
  logic pause;
  logic clear;
  logic dir;
  logic load;
  logic [4:0] load_hr;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic lap;
  logic lap_pop;
  logic one_sec;
  logic [3:0] sec_first;
  logic [3:0] sec_second;
  logic [3:0] min_first;
  logic [3:0] min_second;
  logic [3:0] hour_first;
  logic [3:0] hour_second;
  logic [16:0] lap_data;
  logic [CW-1:0] lap_count;
  logic lap_ovf;
  logic running;
  logic expired;
  logic [3:0] mode_at;
  modport master (
    output start, pause, clear, dir, load, load_hr, load_min, load_sec, lap, lap_pop,
    input one_sec, sec_first, sec_second, min_first, min_second, hour_first, hour_second,
    input lap_data, lap_count, lap_ovf, running, expired, mode_at
  );
  modport slave (
    input start, pause, clear, dir, load, load_hr, load_min, load_sec, lap, lap_pop,
    output one_sec, sec_first, sec_second, min_first, min_second, hour_first, hour_second,
    output lap_data, lap_count, lap_ovf, running, expired, mode_at
  );
endinterface

// File: rtl/stopwatch_lap_timer.sv
// stopwatch_lap_timer: HH:MM:SS up/down stopwatch with prescaled second tick, countdown expiry and lap FIFO
// clk_100MHz: system clock; reset_n: async active-low reset
// bus (slave): pulse commands and preset in; BCD digits, lap FIFO head/occupancy/overflow, status and mode code out
module stopwatch_lap_timer #(
  parameter int CLK_HZ = 100_000_000,
  parameter int HOUR_MAX = 24,
  parameter int LAP_DEPTH = 4
) (
  input logic clk_100MHz,
  input logic reset_n,
  stopwatch_lap_timer_if.slave bus
);
  localparam int PW = $clog2(CLK_HZ);
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
  localparam logic [4:0] HMAX = 5'(HOUR_MAX - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
  state_t st, st_n;
  logic [PW-1:0] pre, pre_n;
  logic [4:0] hr, hr_n, hr_s, ld_hr;
  logic [5:0] mn, mn_n, mn_s, ld_mn;
  logic [5:0] sc, sc_n, sc_s, ld_sc;
  logic dq, dq_n, tick, zero, cy_s, cy_m;
  logic c_ld, c_st, c_pa, c_cmd, lap_ok, pop_ok, push;
  logic [AW-1:0] rd, wr, rd_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [16:0] mem [LAP_DEPTH];
  logic [16:0] cur, head_n, lap_data;
  logic one_sec, running, expired, ovf;
  function automatic logic [7:0] bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction
  assign zero = {hr, mn, sc} == '0;
  assign tick = st == RUN && pre == PMAX;
  // one-second step in the latched direction; carries/borrows ripple sec -> min -> hr
  assign cy_s = dq ? sc == 6'd0 : sc == 6'd59;
  assign cy_m = cy_s && (dq ? mn == 6'd0 : mn == 6'd59);
  assign sc_s = dq ? (sc == 6'd0 ? 6'd59 : sc - 1'b1) : (sc == 6'd59 ? 6'd0 : sc + 1'b1);
  assign mn_s = !cy_s ? mn : dq ? (mn == 6'd0 ? 6'd59 : mn - 1'b1) : (mn == 6'd59 ? 6'd0 : mn + 1'b1);
  assign hr_s = !cy_m ? hr : dq ? (hr == 5'd0 ? HMAX : hr - 1'b1) : (hr == HMAX ? 5'd0 : hr + 1'b1);
  assign ld_hr = {1'b0, bus.load_hr} >= 6'(HOUR_MAX) ? HMAX : bus.load_hr;
  assign ld_mn = bus.load_min > 6'd59 ? 6'd59 : bus.load_min;
  assign ld_sc = bus.load_sec > 6'd59 ? 6'd59 : bus.load_sec;
  // the highest-priority pulse present wins; lap_pop alone may ride along with lap
  assign c_ld = !bus.clear && bus.load;
  assign c_st = !bus.clear && !bus.load && bus.start;
  assign c_pa = !bus.clear && !bus.load && !bus.start && bus.pause;
  assign c_cmd = bus.clear || bus.load || bus.start || bus.pause;
  always_comb begin
    st_n = st;
    pre_n = pre;
    dq_n = dq;
    {hr_n, mn_n, sc_n} = {hr, mn, sc};
    if (st == RUN) pre_n = tick ? '0 : pre + 1'b1;
    if (tick) begin
      {hr_n, mn_n, sc_n} = {hr_s, mn_s, sc_s};
      if (dq && {hr_s, mn_s, sc_s} == '0) st_n = EXPIRED;
    end
    if (bus.clear) begin
      st_n = IDLE;
      pre_n = '0;
      {hr_n, mn_n, sc_n} = '0;
    end else if (c_ld && (st == IDLE || st == PAUSED)) begin
      {hr_n, mn_n, sc_n} = {ld_hr, ld_mn, ld_sc};
      pre_n = '0;
    end else if (c_st && st == IDLE && !(bus.dir && zero)) begin
      st_n = RUN;
      dq_n = bus.dir;
    end else if (c_st && st == PAUSED) begin
      st_n = RUN;
    end else if (c_pa && st_n == RUN) begin
      st_n = PAUSED;
    end
  end
  // lap captures the pre-tick time; head_n bypasses the write when the pushed entry becomes head
  assign cur = {hr, mn, sc};
  assign lap_ok = !c_cmd && bus.lap && (st == RUN || st == PAUSED);
  assign pop_ok = !c_cmd && bus.lap_pop && cnt != '0;
  assign push = lap_ok && (cnt != CW'(LAP_DEPTH) || pop_ok);
  assign rd_n = rd + AW'(pop_ok);
  assign cnt_n = cnt + CW'(push) - CW'(pop_ok);
  assign head_n = cnt_n == '0 ? '0 : (push && rd_n == wr) ? cur : mem[rd_n];
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      pre <= '0;
      {hr, mn, sc} <= '0;
      dq <= 1'b0;
      running <= 1'b0;
      expired <= 1'b0;
      one_sec <= 1'b0;
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      lap_data <= '0;
    end else begin
      st <= st_n;
      pre <= pre_n;
      {hr, mn, sc} <= {hr_n, mn_n, sc_n};
      dq <= dq_n;
      running <= st_n == RUN;
      expired <= st_n == EXPIRED;
      one_sec <= tick && !bus.clear;
      if (bus.clear) begin
        rd <= '0;
        wr <= '0;
        cnt <= '0;
        ovf <= 1'b0;
        lap_data <= '0;
      end else begin
        rd <= rd_n;
        wr <= wr + AW'(push);
        cnt <= cnt_n;
        lap_data <= head_n;
        if (lap_ok && !push) ovf <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk_100MHz) if (push) mem[wr] <= cur;
  assign {bus.hour_first, bus.hour_second} = bcd({1'b0, hr});
  assign {bus.min_first, bus.min_second} = bcd(mn);
  assign {bus.sec_first, bus.sec_second} = bcd(sc);
  assign bus.one_sec = one_sec;
  assign bus.lap_data = lap_data;
  assign bus.lap_count = cnt;
  assign bus.lap_ovf = ovf;
  assign bus.running = running;
  assign bus.expired = expired;
  assign bus.mode_at = expired ? 4'hd : dq ? 4'hc : 4'hb;
endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// tb_stopwatch_lap_timer: directed sequences, load table and random commands against a seconds-count reference model
module tb_stopwatch_lap_timer;
  localparam int CLK_HZ = 10;
  localparam int HOUR_MAX = 24;
  localparam int DEPTH = 4;
  localparam int TOT = HOUR_MAX * 3600;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_EXP = 3;
  localparam logic [5:0] C_CLR = 6'b100000, C_LD = 6'b010000, C_ST = 6'b001000;
  localparam logic [5:0] C_PA = 6'b000100, C_LAP = 6'b000010, C_POP = 6'b000001;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  stopwatch_lap_timer_if #(.LAP_DEPTH(DEPTH)) bus();
  stopwatch_lap_timer #(.CLK_HZ(CLK_HZ), .HOUR_MAX(HOUR_MAX), .LAP_DEPTH(DEPTH)) dut (
    .clk_100MHz(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );
  int passed = 0;
  int total = 0;
  int m_st, m_t, m_pre;
  logic m_dq, m_ovf, m_one;
  logic [16:0] m_data;
  logic [16:0] m_q[$];
  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [23:0] dig;
  } ld_vec_t;
  ld_vec_t tbl[7];
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask
  function automatic logic [16:0] pack(input int t);
    return {5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)};
  endfunction
  function automatic logic [23:0] digits_of(input int t);
    int h, mi, s;
    h = t / 3600;
    mi = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction
  function automatic logic [23:0] dig_act();
    return {bus.hour_first, bus.hour_second, bus.min_first, bus.min_second, bus.sec_first, bus.sec_second};
  endfunction
  function automatic logic [51:0] exp_vec();
    logic [3:0] mode;
    mode = m_st == S_EXP ? 4'hd : m_dq ? 4'hc : 4'hb;
    return {m_one, digits_of(m_t), m_data, 3'(m_q.size()), m_ovf, m_st == S_RUN, m_st == S_EXP, mode};
  endfunction
  function automatic logic [51:0] act_vec();
    return {bus.one_sec, dig_act(), bus.lap_data, bus.lap_count, bus.lap_ovf, bus.running, bus.expired, bus.mode_at};
  endfunction
  task automatic model_reset();
    m_st = S_IDLE;
    m_t = 0;
    m_pre = 0;
    m_dq = 1'b0;
    m_ovf = 1'b0;
    m_one = 1'b0;
    m_data = '0;
    m_q.delete();
  endtask
  task automatic model_step();
    logic cl, ld, st, pa, lp, pp, tick, lapok, popok;
    int nst, h, mi, s;
    cl = bus.clear;
    ld = !cl && bus.load;
    st = !cl && !bus.load && bus.start;
    pa = !cl && !bus.load && !bus.start && bus.pause;
    lp = !(cl || bus.load || bus.start || bus.pause) && bus.lap;
    pp = !(cl || bus.load || bus.start || bus.pause) && bus.lap_pop;
    tick = m_st == S_RUN && m_pre == CLK_HZ - 1;
    lapok = lp && (m_st == S_RUN || m_st == S_PAUSED);
    popok = pp && m_q.size() > 0;
    if (lapok && !popok && m_q.size() == DEPTH) m_ovf = 1'b1;
    if (popok) void'(m_q.pop_front());
    if (lapok && m_q.size() < DEPTH) m_q.push_back(pack(m_t));
    nst = m_st;
    if (m_st == S_RUN) m_pre = tick ? 0 : m_pre + 1;
    if (tick) begin
      m_t = m_dq ? (m_t + TOT - 1) % TOT : (m_t + 1) % TOT;
      if (m_dq && m_t == 0) nst = S_EXP;
    end
    if (cl) begin
      nst = S_IDLE;
      m_t = 0;
      m_pre = 0;
      m_q.delete();
      m_ovf = 1'b0;
    end else if (ld) begin
      if (m_st == S_IDLE || m_st == S_PAUSED) begin
        h = int'(bus.load_hr) > HOUR_MAX - 1 ? HOUR_MAX - 1 : int'(bus.load_hr);
        mi = int'(bus.load_min) > 59 ? 59 : int'(bus.load_min);
        s = int'(bus.load_sec) > 59 ? 59 : int'(bus.load_sec);
        m_t = h * 3600 + mi * 60 + s;
        m_pre = 0;
      end
    end else if (st) begin
      if (m_st == S_IDLE && !(bus.dir && m_t == 0)) begin
        nst = S_RUN;
        m_dq = bus.dir;
      end else if (m_st == S_PAUSED) nst = S_RUN;
    end else if (pa && nst == S_RUN) nst = S_PAUSED;
    m_st = nst;
    m_one = tick && !cl;
    m_data = m_q.size() > 0 ? m_q[0] : '0;
  endtask
  task automatic cyc(input logic [5:0] c);
    {bus.clear, bus.load, bus.start, bus.pause, bus.lap, bus.lap_pop} = c;
    @(posedge clk);
    model_step();
    #1;
    {bus.clear, bus.load, bus.start, bus.pause, bus.lap, bus.lap_pop} = '0;
    chk("cycle_model", 64'(act_vec()), 64'(exp_vec()));
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(6'b0);
  endtask
  task automatic do_load(input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s);
    bus.load_hr = h;
    bus.load_min = mi;
    bus.load_sec = s;
    cyc(C_LD);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int pulses, last, bad, n, r;
    logic [5:0] c;
    tbl[0] = '{5'd31, 6'd63, 6'd63, 24'h235959};
    tbl[1] = '{5'd12, 6'd34, 6'd56, 24'h123456};
    tbl[2] = '{5'd23, 6'd59, 6'd59, 24'h235959};
    tbl[3] = '{5'd24, 6'd60, 6'd60, 24'h235959};
    tbl[4] = '{5'd0, 6'd0, 6'd0, 24'h000000};
    tbl[5] = '{5'd9, 6'd5, 6'd7, 24'h090507};
    tbl[6] = '{5'd30, 6'd0, 6'd61, 24'h230059};
    {bus.clear, bus.load, bus.start, bus.pause, bus.lap, bus.lap_pop, bus.dir} = '0;
    bus.load_hr = '0;
    bus.load_min = '0;
    bus.load_sec = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    chk("reset_state", 64'(act_vec()), 64'(exp_vec()));
    chk("reset_mode", 64'(bus.mode_at), 64'(4'hb));
    bus.dir = 1'b0;
    cyc(C_ST);
    pulses = 0;
    last = -1;
    bad = 0;
    for (int i = 1; i <= 600; i++) begin
      cyc(6'b0);
      if (bus.one_sec) begin
        if ((last < 0 && i != 10) || (last >= 0 && i - last != 10)) bad++;
        last = i;
        pulses++;
      end
    end
    chk("t1_pulses", 64'(pulses), 64'(60));
    chk("t1_spacing", 64'(bad), 64'(0));
    chk("t1_digits", 64'(dig_act()), 64'(24'h000100));
    chk("t1_running", 64'(bus.running), 64'(1));
    cyc(C_CLR);
    do_load(5'd0, 6'd0, 6'd3);
    bus.dir = 1'b1;
    cyc(C_ST);
    n = 0;
    while (!bus.expired && n < 100) begin
      cyc(6'b0);
      n++;
    end
    chk("t2_expire_cycle", 64'(n), 64'(30));
    chk("t2_expire_pulse", 64'(bus.one_sec), 64'(1));
    chk("t2_digits", 64'(dig_act()), 64'(0));
    chk("t2_mode", 64'(bus.mode_at), 64'(4'hd));
    cyc(C_ST);
    chk("t2_start_in_expired", 64'({bus.expired, bus.running}), 64'(2'b10));
    cyc(C_CLR);
    chk("t2_clear_mode", 64'(bus.mode_at), 64'(4'hc));
    chk("t2_clear_idle", 64'({bus.expired, bus.running}), 64'(0));
    cyc(C_ST);
    chk("t2_zero_down_start", 64'(bus.running), 64'(0));
    bus.dir = 1'b0;
    do_load(5'd23, 6'd59, 6'd58);
    cyc(C_ST);
    idle(20);
    chk("t3_wrap_digits", 64'(dig_act()), 64'(0));
    chk("t3_wrap_running", 64'(bus.running), 64'(1));
    cyc(C_CLR);
    do_load(5'd0, 6'd0, 6'd5);
    cyc(C_ST);
    idle(6);
    cyc(C_PA);
    idle(50);
    chk("t4_pause_hold", 64'(dig_act()), 64'(24'h000005));
    chk("t4_paused", 64'(bus.running), 64'(0));
    cyc(C_ST);
    n = 0;
    do begin
      cyc(6'b0);
      n++;
    end while (!bus.one_sec && n < 20);
    chk("t4_resume_latency", 64'(n), 64'(3));
    chk("t4_after_resume", 64'(dig_act()), 64'(24'h000006));
    cyc(C_CLR);
    cyc(C_ST);
    for (int i = 0; i < 5; i++) begin
      idle(9);
      cyc(C_LAP);
    end
    chk("t5_full_count", 64'(bus.lap_count), 64'(4));
    chk("t5_ovf", 64'(bus.lap_ovf), 64'(1));
    for (int i = 0; i < 4; i++) begin
      chk("t5_head", 64'(bus.lap_data), 64'(i));
      cyc(C_POP);
    end
    chk("t5_empty_data", 64'(bus.lap_data), 64'(0));
    chk("t5_empty_count", 64'(bus.lap_count), 64'(0));
    cyc(C_POP);
    chk("t5_pop_empty", 64'(bus.lap_count), 64'(0));
    cyc(C_CLR);
    cyc(C_ST);
    for (int i = 0; i < 4; i++) begin
      idle(2);
      cyc(C_LAP);
    end
    chk("t5_refill", 64'(bus.lap_count), 64'(4));
    cyc(C_LAP | C_POP);
    chk("t5_push_pop_count", 64'(bus.lap_count), 64'(4));
    chk("t5_push_pop_ovf", 64'(bus.lap_ovf), 64'(0));
    foreach (tbl[i]) begin
      cyc(C_CLR);
      do_load(tbl[i].h, tbl[i].m, tbl[i].s);
      chk("t6_load_table", 64'(dig_act()), 64'(tbl[i].dig));
    end
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      bus.load_hr = 5'($urandom);
      bus.load_min = 6'($urandom);
      bus.load_sec = 6'($urandom);
      bus.dir = 1'($urandom);
      c = r < 2 ? C_CLR : r < 7 ? C_LD : r < 15 ? C_ST : r < 20 ? C_PA :
          r < 28 ? C_LAP : r < 34 ? C_POP : r < 37 ? (C_LAP | C_POP) : r < 39 ? 6'($urandom) : 6'b0;
      cyc(c);
    end
    cyc(C_CLR);
    bus.dir = 1'b0;
    do_load(5'd1, 6'd2, 6'd3);
    cyc(C_ST);
    idle(15);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("t8_async_reset", 64'(act_vec()), 64'(exp_vec()));
    chk("t8_reset_digits", 64'(dig_act()), 64'(0));
    chk("t8_reset_status", 64'({bus.running, bus.one_sec, bus.mode_at}), 64'(6'h0b));
    #2;
    reset_n = 1'b1;
    do_load(5'd31, 6'd63, 6'd63);
    chk("t8_saturate", 64'(dig_act()), 64'(24'h235959));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
